lsu_ctrl: RTL

- Load/store unit sitting directly downstream of the control unit, alongside the ALU.
- Consumes the control unit's memory-control outputs (MemWrite, ResultSrc, length, signExt) plus the ALU address and rs2 data.
- Drives a word-wide data memory over a req/ready handshake, stalls the core while an access is outstanding, and returns the aligned, extended load data to the writeback mux.

---
 rtl/lsu_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the control unit and a word-wide data memory.
// Optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            length,
  input  logic                  signExt,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  misaligned,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  len_q;
  logic        sext_q;
  logic        access;
  logic        aligned;
  logic        start;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh;
  logic [31:0] ld;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          expire;
  assign expire  = (cnt == CW'(TIMEOUT - 1));
  assign bus_err = (state == DONE) && err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign access = MemRead | MemWrite;

  // Alignment check; length 11 behaves as a word.
  always_comb begin
    aligned = 1'b1;
    unique case (1'b1)
      length == 2'b00: aligned = 1'b1;
      length == 2'b01: aligned = ~addr[0];
      default:         aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign start      = (state == IDLE) && access && aligned;
  assign stall      = start || (state == REQ);
  assign misaligned = (state == IDLE) && access && !aligned;

  // Byte-enable and lane-replicated store data for the new request.
  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    unique case (1'b1)
      length == 2'b00: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      length == 2'b01: begin
        be_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
  end

  // Lane extraction and extension of the returned word (signExt=1 zero-fills).
  always_comb begin
    sh = mem_rdata >> {off_q, 3'b000};
    ld = sh;
    unique case (1'b1)
      len_q == 2'b00:
        ld = sext_q ? {24'h0, sh[7:0]}
                    : {{24{sh[7]}}, sh[7:0]};
      len_q == 2'b01:
        ld = sext_q ? {16'h0, sh[15:0]}
                    : {{16{sh[15]}}, sh[15:0]};
      default:
        ld = sh;
    endcase
  end

  // Access sequencer with registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'h0;
      rdata     <= 32'h0;
      off_q     <= 2'b0;
      len_q     <= 2'b0;
      sext_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wd_n;
            off_q     <= addr[1:0];
            len_q     <= length;
            sext_q    <= signExt;
`ifdef LSU_TIMEOUT_EN
            cnt       <= '0;
            err_q     <= 1'b0;
`endif
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata <= ld;
            state   <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (expire) begin
            mem_req <= 1'b0;
            err_q   <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
